// File: rtl/id_pipe_pkg.sv
// id_pipe_pkg: shared RV64 opcode/funct3 constants, formats and immediate helper for the ID stage.
package id_pipe_pkg;
    localparam int XLEN_DEF = 64;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [2:0] F3_ADD = 3'd0;
    localparam logic [2:0] F3_BEQ = 3'd0;
    localparam logic [2:0] F3_SD  = 3'd3;
    localparam logic [2:0] F3_LD  = 3'd3;
    typedef enum logic [1:0] {WLEN_B, WLEN_H, WLEN_W, WLEN_D} wlen_e;
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;
    function automatic fmt_e fmt_of(input logic [6:0] op);
        return (op == OP_LOAD || op == OP_IMM || op == OP_JALR || op == OP_SYSTEM) ? FMT_I :
               (op == OP_STORE)                  ? FMT_S :
               (op == OP_BRANCH)                 ? FMT_B :
               (op == OP_LUI || op == OP_AUIPC)  ? FMT_U :
               (op == OP_JAL)                    ? FMT_J :
               (op == OP_OP)                     ? FMT_R : FMT_X;
    endfunction
    // Every RV immediate fits in 32 bits; the caller sign-extends to XLEN.
    function automatic logic [31:0] imm32(input logic [31:0] inst);
        fmt_e f;
        f = fmt_of(inst[6:0]);
        return (f == FMT_I) ? {{20{inst[31]}}, inst[31:20]} :
               (f == FMT_S) ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
               (f == FMT_B) ? {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0} :
               (f == FMT_U) ? {inst[31:12], 12'b0} :
               (f == FMT_J) ? {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0} : 32'd0;
    endfunction
endpackage

// File: rtl/id_pipe_fwd_sel.sv
// fwd_sel: priority forward mux for one source operand; the lowest matching index wins.
module fwd_sel #(
    parameter int XLEN = 64,
    parameter int NFWD = 3
) (
    input  logic [4:0]           i_addr,
    input  logic [XLEN-1:0]      i_rf_data,
    input  logic [NFWD-1:0]      i_wreg,
    input  logic [5*NFWD-1:0]    i_rd_addr,
    input  logic [XLEN*NFWD-1:0] i_wdata,
    input  logic [NFWD-1:0]      i_pending,
    output logic [XLEN-1:0]      o_data,
    output logic                 o_pending
);
    always_comb begin
        o_data    = i_rf_data;
        o_pending = 1'b0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (i_wreg[k] && i_rd_addr[5*k +: 5] == i_addr) begin
                o_data    = i_wdata[XLEN*k +: XLEN];
                o_pending = i_pending[k];
            end
        end
        if (i_addr == 5'd0) begin
            o_data    = '0;
            o_pending = 1'b0;
        end
    end
endmodule

// File: rtl/id_pipe.sv
// id_pipe: registered RV64 decode stage with priority forwarding, load-use stall and stall counter.
module id_pipe
    import id_pipe_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NFWD  = 3,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [31:0]          inst_i,
    input  logic [XLEN-1:0]      pc_i,
    output logic [4:0]           rs1_addr_o,
    output logic [4:0]           rs2_addr_o,
    input  logic [XLEN-1:0]      rs1_data_i,
    input  logic [XLEN-1:0]      rs2_data_i,
    input  logic [NFWD-1:0]      fwd_wreg_i,
    input  logic [5*NFWD-1:0]    fwd_rd_addr_i,
    input  logic [XLEN*NFWD-1:0] fwd_wdata_i,
    input  logic [NFWD-1:0]      fwd_pending_i,
    input  logic                 flush_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [6:0]           opcode_o,
    output logic [2:0]           funct3_o,
    output logic [6:0]           funct7_o,
    output logic [4:0]           rd_addr_o,
    output logic                 wreg_o,
    output logic [XLEN-1:0]      imm_o,
    output logic [XLEN-1:0]      rs1_data_o,
    output logic [XLEN-1:0]      rs2_data_o,
    output logic [XLEN-1:0]      pc_o,
    output logic                 mem_req_o,
    output logic                 mem_wen_o,
    output logic [1:0]           mem_wlen_o,
    output logic [CNT_W-1:0]     stall_cnt_o
);
    logic [XLEN-1:0]  w_rs1_val, w_rs2_val;
    logic             w_rs1_pend, w_rs2_pend, w_use_rs1, w_use_rs2, w_hazard, w_accept;
    logic             w_is_load, w_is_store, w_wreg;
    logic [1:0]       w_wlen;
    logic [31:0]      w_imm32;
    fmt_e             w_fmt;
    logic             r_valid, r_wreg, r_mem_req, r_mem_wen;
    logic [6:0]       r_opcode, r_funct7;
    logic [2:0]       r_funct3;
    logic [4:0]       r_rd;
    logic [1:0]       r_wlen;
    logic [XLEN-1:0]  r_imm, r_rs1, r_rs2, r_pc;
    logic [CNT_W-1:0] r_stall_cnt;

    assign rs1_addr_o = inst_i[19:15];
    assign rs2_addr_o = inst_i[24:20];

    fwd_sel #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_rs1 (
        .i_addr(rs1_addr_o), .i_rf_data(rs1_data_i), .i_wreg(fwd_wreg_i), .i_rd_addr(fwd_rd_addr_i),
        .i_wdata(fwd_wdata_i), .i_pending(fwd_pending_i), .o_data(w_rs1_val), .o_pending(w_rs1_pend)
    );
    fwd_sel #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_rs2 (
        .i_addr(rs2_addr_o), .i_rf_data(rs2_data_i), .i_wreg(fwd_wreg_i), .i_rd_addr(fwd_rd_addr_i),
        .i_wdata(fwd_wdata_i), .i_pending(fwd_pending_i), .o_data(w_rs2_val), .o_pending(w_rs2_pend)
    );

    assign w_fmt      = fmt_of(inst_i[6:0]);
    assign w_use_rs1  = !(w_fmt == FMT_U || w_fmt == FMT_J);
    assign w_use_rs2  = w_fmt inside {FMT_R, FMT_S, FMT_B};
    assign w_hazard   = (w_rs1_pend && w_use_rs1) || (w_rs2_pend && w_use_rs2);
    assign in_ready_o = (!r_valid || out_ready_i) && !w_hazard && !flush_i;
    assign w_accept   = in_valid_i && in_ready_o;
    assign w_imm32    = imm32(inst_i);
    assign w_is_load  = inst_i[6:0] == OP_LOAD;
    assign w_is_store = inst_i[6:0] == OP_STORE;
    assign w_wreg     = !(w_fmt == FMT_B || w_fmt == FMT_S || inst_i[11:7] == 5'd0);
    assign w_wlen     = (w_is_load || w_is_store) ? inst_i[13:12] : WLEN_B;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid     <= 1'b0;
            r_opcode    <= '0;
            r_funct3    <= '0;
            r_funct7    <= '0;
            r_rd        <= '0;
            r_wreg      <= 1'b0;
            r_imm       <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_pc        <= '0;
            r_mem_req   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_wlen      <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (flush_i) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid   <= 1'b1;
                r_opcode  <= inst_i[6:0];
                r_funct3  <= inst_i[14:12];
                r_funct7  <= inst_i[31:25];
                r_rd      <= inst_i[11:7];
                r_wreg    <= w_wreg;
                r_imm     <= {{(XLEN-32){w_imm32[31]}}, w_imm32};
                r_rs1     <= w_rs1_val;
                r_rs2     <= w_rs2_val;
                r_pc      <= pc_i;
                r_mem_req <= w_is_load || w_is_store;
                r_mem_wen <= w_is_store;
                r_wlen    <= w_wlen;
            end else if (out_ready_i) begin
                r_valid <= 1'b0;
            end
            if (in_valid_i && w_hazard && !flush_i && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid_o = r_valid;
    assign opcode_o    = r_opcode;
    assign funct3_o    = r_funct3;
    assign funct7_o    = r_funct7;
    assign rd_addr_o   = r_rd;
    assign wreg_o      = r_wreg;
    assign imm_o       = r_imm;
    assign rs1_data_o  = r_rs1;
    assign rs2_data_o  = r_rs2;
    assign pc_o        = r_pc;
    assign mem_req_o   = r_mem_req;
    assign mem_wen_o   = r_mem_wen;
    assign mem_wlen_o  = r_wlen;
    assign stall_cnt_o = r_stall_cnt;
endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: directed test-plan scenarios plus randomized cycle-level reference-model checking of id_pipe.
module tb_id_pipe;
    import id_pipe_pkg::*;
    localparam int XLEN = 64, NFWD = 3, CNT_W = 32;
    logic clk = 1'b0, rst = 1'b1;
    logic in_valid_i = 0, in_ready_o, flush_i = 0, out_valid_o, out_ready_i = 0;
    logic [31:0] inst_i = '0;
    logic [XLEN-1:0] pc_i = '0, rs1_data_i = '0, rs2_data_i = '0;
    logic [4:0] rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [NFWD-1:0] fwd_wreg_i = '0, fwd_pending_i = '0;
    logic [5*NFWD-1:0] fwd_rd_addr_i = '0;
    logic [XLEN*NFWD-1:0] fwd_wdata_i = '0;
    logic [6:0] opcode_o, funct7_o;
    logic [2:0] funct3_o;
    logic wreg_o, mem_req_o, mem_wen_o;
    logic [1:0] mem_wlen_o;
    logic [XLEN-1:0] imm_o, rs1_data_o, rs2_data_o, pc_o;
    logic [CNT_W-1:0] stall_cnt_o;
    int checks = 0, errors = 0;

    id_pipe #(.XLEN(XLEN), .NFWD(NFWD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .inst_i(inst_i), .pc_i(pc_i),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .fwd_wreg_i(fwd_wreg_i), .fwd_rd_addr_i(fwd_rd_addr_i), .fwd_wdata_i(fwd_wdata_i),
        .fwd_pending_i(fwd_pending_i), .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o), .rd_addr_o(rd_addr_o), .wreg_o(wreg_o),
        .imm_o(imm_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .pc_o(pc_o), .mem_req_o(mem_req_o),
        .mem_wen_o(mem_wen_o), .mem_wlen_o(mem_wlen_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fwd(input int k, input logic en, input logic [4:0] rd, input logic [63:0] d, input logic p);
        fwd_wreg_i[k] = en;
        fwd_rd_addr_i[5*k +: 5] = rd;
        fwd_wdata_i[64*k +: 64] = d;
        fwd_pending_i[k] = p;
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [4:0] rd);
        return {imm, rs1, F3_ADD, rd, OP_IMM};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    endfunction

    // Reference immediate: field value as a signed number, scaled by 2 for branch/jump offsets.
    function automatic longint ref_imm(input logic [31:0] x);
        logic signed [11:0] i12;
        logic signed [11:0] b12;
        logic signed [19:0] j20;
        int u;
        i12 = x[31:20];
        b12 = {x[31], x[7], x[30:25], x[11:8]};
        j20 = {x[31], x[19:12], x[20], x[30:21]};
        u = {x[31:12], 12'h000};
        case (x[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: return longint'(i12);
            OP_STORE: begin i12 = {x[31:25], x[11:7]}; return longint'(i12); end
            OP_BRANCH: return longint'(b12) * 2;
            OP_LUI, OP_AUIPC: return longint'(u);
            OP_JAL: return longint'(j20) * 2;
            default: return 0;
        endcase
    endfunction

    function automatic void ref_opnd(input logic [4:0] a, input logic [63:0] rf, output logic [63:0] v, output logic p);
        v = rf;
        p = 1'b0;
        if (a == 5'd0) begin v = '0; return; end
        for (int k = 0; k < NFWD; k++)
            if (fwd_wreg_i[k] && fwd_rd_addr_i[5*k +: 5] == a) begin
                v = fwd_wdata_i[64*k +: 64];
                p = fwd_pending_i[k];
                return;
            end
    endfunction

    logic m_valid;
    logic [63:0] m_imm, m_a, m_b, m_pc, m_ctrl;
    logic [31:0] m_cnt;
    logic [6:0] ops [11] = '{OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_OP, OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM, 7'h0B};

    initial begin
        logic [63:0] v1, v2;
        logic p1, p2, u1, u2, hz, rdy, wr;
        logic [31:0] x;
        logic [6:0] op;
        #1 rst = 1'b0;
        #2;
        check("rst_valid", 64'(out_valid_o), 0);
        check("rst_cnt", 64'(stall_cnt_o), 0);
        check("rst_imm", imm_o, 0);
        @(negedge clk) rst = 1'b1;
        tick();
        // Forward priority: ADD x3,x1,x2
        inst_i = {7'd0, 5'd2, 5'd1, F3_ADD, 5'd3, OP_OP};
        set_fwd(0, 1, 5'd1, 64'hAA, 0);
        set_fwd(1, 0, 5'd0, 64'h11, 0);
        set_fwd(2, 1, 5'd1, 64'hBB, 0);
        rs1_data_i = 64'hCC; rs2_data_i = 64'h22;
        in_valid_i = 1; out_ready_i = 1;
        #1;
        check("fwd_ready", 64'(in_ready_o), 1);
        check("rs1_addr", 64'(rs1_addr_o), 1);
        tick();
        check("fwd_valid", 64'(out_valid_o), 1);
        check("fwd_src0", rs1_data_o, 64'hAA);
        check("fwd_rs2_rf", rs2_data_o, 64'h22);
        fwd_wreg_i[0] = 0;
        tick();
        check("fwd_src2", rs1_data_o, 64'hBB);
        // Load-use: SD x5,8(x6) with x5 pending in EX
        fwd_wreg_i = '0;
        set_fwd(0, 1, 5'd5, 64'h55, 1);
        inst_i = {7'd0, 5'd5, 5'd6, F3_SD, 5'd8, OP_STORE};
        #1 check("lu_ready", 64'(in_ready_o), 0);
        tick();
        check("lu_cnt1", 64'(stall_cnt_o), 1);
        tick();
        check("lu_cnt2", 64'(stall_cnt_o), 2);
        fwd_pending_i = '0;
        #1 check("lu_ready_go", 64'(in_ready_o), 1);
        tick();
        check("lu_valid", 64'(out_valid_o), 1);
        check("lu_ctrl", {mem_req_o, mem_wen_o, mem_wlen_o, wreg_o}, {1'b1, 1'b1, 2'd3, 1'b0});
        check("lu_imm", imm_o, 8);
        check("lu_rs2", rs2_data_o, 64'h55);
        check("lu_cnt_hold", 64'(stall_cnt_o), 2);
        // Immediates
        fwd_wreg_i = '0;
        inst_i = enc_b(13'h1FFC, 5'd0, 5'd0);
        tick();
        check("imm_beq", imm_o, 64'hFFFF_FFFF_FFFF_FFFC);
        inst_i = {20'h80000, 5'd1, OP_LUI};
        tick();
        check("imm_lui", imm_o, 64'hFFFF_FFFF_8000_0000);
        inst_i = enc_j(21'd2048, 5'd1);
        tick();
        check("imm_jal", imm_o, 64'h800);
        // Backpressure with three ADDIs
        in_valid_i = 0;
        tick();
        check("bp_drained", 64'(out_valid_o), 0);
        inst_i = enc_i(12'd1, 5'd0, 5'd1); in_valid_i = 1; out_ready_i = 0;
        tick();
        check("bp_first", imm_o, 1);
        inst_i = enc_i(12'd2, 5'd0, 5'd2);
        #1 check("bp_ready", 64'(in_ready_o), 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("bp_hold", {out_valid_o, imm_o[62:0]}, {1'b1, 63'd1});
        end
        out_ready_i = 1;
        tick();
        check("bp_second", {out_valid_o, imm_o[62:0]}, {1'b1, 63'd2});
        inst_i = enc_i(12'd3, 5'd0, 5'd3);
        tick();
        check("bp_third", {out_valid_o, imm_o[62:0]}, {1'b1, 63'd3});
        in_valid_i = 0;
        tick();
        check("bp_empty", 64'(out_valid_o), 0);
        // Flush on a cycle that would otherwise accept
        inst_i = enc_i(12'd7, 5'd0, 5'd1); in_valid_i = 1;
        tick();
        check("fl_pre", imm_o, 7);
        inst_i = enc_i(12'd9, 5'd0, 5'd1); flush_i = 1; out_ready_i = 0;
        #1 check("fl_ready", 64'(in_ready_o), 0);
        tick();
        check("fl_valid", 64'(out_valid_o), 0);
        flush_i = 0;
        tick();
        check("fl_after", {out_valid_o, imm_o[62:0]}, {1'b1, 63'd9});
        // Asynchronous reset mid-cycle
        #2 rst = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid_o), 0);
        check("arst_cnt", 64'(stall_cnt_o), 0);
        check("arst_imm", imm_o, 0);
        in_valid_i = 0; flush_i = 0; fwd_wreg_i = '0; fwd_pending_i = '0;
        @(negedge clk) rst = 1'b1;
        m_valid = 0; m_imm = 0; m_a = 0; m_b = 0; m_pc = 0; m_ctrl = 0; m_cnt = 0;
        tick();
        // Randomized run against the reference model
        for (int c = 0; c < 3000; c++) begin
            x = $urandom;
            x[6:0] = ops[$urandom_range(0, 10)];
            x[19:15] = 5'($urandom_range(0, 3));
            x[24:20] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) x[11:7] = 5'd0;
            inst_i = x;
            pc_i = {$urandom, $urandom};
            rs1_data_i = {$urandom, $urandom};
            rs2_data_i = {$urandom, $urandom};
            for (int k = 0; k < NFWD; k++)
                set_fwd(k, 1'($urandom), 5'($urandom_range(0, 3)), {$urandom, $urandom}, $urandom_range(0, 5) == 0);
            flush_i = $urandom_range(0, 15) == 0;
            in_valid_i = $urandom_range(0, 3) != 0;
            out_ready_i = $urandom_range(0, 3) != 0;
            #1;
            op = x[6:0];
            ref_opnd(x[19:15], rs1_data_i, v1, p1);
            ref_opnd(x[24:20], rs2_data_i, v2, p2);
            u1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
            u2 = op == OP_OP || op == OP_STORE || op == OP_BRANCH;
            hz = (p1 && u1) || (p2 && u2);
            rdy = (!m_valid || out_ready_i) && !hz && !flush_i;
            check("r_ready", 64'(in_ready_o), 64'(rdy));
            check("r_addr", {rs1_addr_o, rs2_addr_o}, {x[19:15], x[24:20]});
            if (flush_i) m_valid = 0;
            else if (in_valid_i && rdy) begin
                wr = !(op == OP_BRANCH || op == OP_STORE || x[11:7] == 0);
                m_valid = 1;
                m_imm = ref_imm(x);
                m_a = v1;
                m_b = v2;
                m_pc = pc_i;
                m_ctrl = 64'({op, x[14:12], x[31:25], x[11:7], wr, op == OP_LOAD || op == OP_STORE, op == OP_STORE,
                              (op == OP_LOAD || op == OP_STORE) ? x[13:12] : 2'd0});
            end else if (out_ready_i) m_valid = 0;
            if (in_valid_i && hz && !flush_i && m_cnt != '1) m_cnt++;
            tick();
            check("r_valid", 64'(out_valid_o), 64'(m_valid));
            check("r_imm", imm_o, m_imm);
            check("r_rs1", rs1_data_o, m_a);
            check("r_rs2", rs2_data_o, m_b);
            check("r_pc", pc_o, m_pc);
            check("r_ctrl", 64'({opcode_o, funct3_o, funct7_o, rd_addr_o, wreg_o, mem_req_o, mem_wen_o, mem_wlen_o}), m_ctrl);
            check("r_cnt", 64'(stall_cnt_o), 64'(m_cnt));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
